icache_fetch: RTL and testbench

- Instruction-side cache and fetcher; the producing end of the icache→IF queue interface.
- Accepts a fetch PC from the PC/branch unit and looks it up in a direct-mapped cache.
- On a miss, refills a 16-byte line from the memory controller.
- Delivers one 32-bit instruction per request to the IF queue via a one-cycle valid pulse.
- Respects IF back-pressure (IF full) and supports flush on misprediction.

---
 rtl/icache_fetch.sv | 147 ++++++++++++++
 tb/tb_icache_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache with 16-byte lines and a word-serial refill engine.
// Delivers one instruction per accepted fetch as a single-cycle pulse toward the IF queue.
module icache_fetch #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        pc_valid_in,
    input  logic [31:0] pc_in,
    output logic        pc_ready_out,
    input  logic        if_full_in,
    input  logic        flush_in,
    output logic        icache_have_input,
    output logic [31:0] icache_instr_input,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_valid_in,
    input  logic [31:0] mem_data_in
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;

    state_t                 state_reg, state_next;
    logic [31:2]            req_pc_reg;
    logic [1:0]             k_reg;
    logic [LINES-1:0]       valid_reg;
    logic                   have_reg;
    logic [31:0]            instr_reg;
    logic                   mem_req_reg;
    logic [31:0]            mem_addr_reg;

    logic [TAG_BITS-1:0]    tag_mem  [LINES];
    logic [31:0]            data_mem [LINES*4];

    logic [INDEX_BITS-1:0]  req_index;
    logic [TAG_BITS-1:0]    req_tag;
    logic [1:0]             req_offset;
    logic                   hit;
    logic                   refill_start;
    logic                   word_in;
    logic                   last_word;
    logic [LINES-1:0]       valid_clr;
    logic [LINES-1:0]       valid_set;
    logic                   unused_pc_bits;

    assign unused_pc_bits = ^pc_in[1:0];

    assign req_offset = req_pc_reg[3:2];
    assign req_index  = req_pc_reg[INDEX_BITS+3:4];
    assign req_tag    = req_pc_reg[31:INDEX_BITS+4];

    assign hit          = valid_reg[req_index] && (tag_mem[req_index] == req_tag);
    assign refill_start = (state_reg == LOOKUP) && !hit;
    assign word_in      = (state_reg == REFILL) && mem_valid_in;
    assign last_word    = word_in && (k_reg == 2'd3);

    // The line is invalidated on refill entry and only re-validated once all four words landed.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line_valid
            assign valid_clr[gi] = refill_start && (req_index == INDEX_BITS'(gi));
            assign valid_set[gi] = last_word && (req_index == INDEX_BITS'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (pc_valid_in) state_next = LOOKUP;
            LOOKUP: begin
                if (!hit)
                    state_next = REFILL;
                else if (!if_full_in)
                    state_next = IDLE;
            end
            REFILL:  if (last_word) state_next = LOOKUP;
            default: state_next = IDLE;
        endcase
        if (flush_in)
            state_next = IDLE;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            req_pc_reg   <= '0;
            k_reg        <= 2'd0;
            valid_reg    <= '0;
            have_reg     <= 1'b0;
            instr_reg    <= 32'd0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= 32'd0;
        end else if (rdy_in) begin
            state_reg <= state_next;
            have_reg  <= 1'b0;
            if (flush_in) begin
                mem_req_reg <= 1'b0;
            end else begin
                valid_reg <= (valid_reg & ~valid_clr) | valid_set;
                unique case (state_reg)
                    IDLE: if (pc_valid_in) req_pc_reg <= pc_in[31:2];
                    LOOKUP: begin
                        if (hit) begin
                            if (!if_full_in) begin
                                have_reg  <= 1'b1;
                                instr_reg <= data_mem[{req_index, req_offset}];
                            end
                        end else begin
                            k_reg        <= 2'd0;
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= {req_pc_reg[31:4], 4'b0000};
                        end
                    end
                    REFILL: begin
                        if (mem_valid_in) begin
                            k_reg <= k_reg + 2'd1;
                            if (k_reg == 2'd3)
                                mem_req_reg <= 1'b0;
                            else
                                mem_addr_reg <= {req_pc_reg[31:4], k_reg + 2'd1, 2'b00};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Tag and data storage carry no reset; validity is tracked separately.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !flush_in) begin
            if (word_in)
                data_mem[{req_index, k_reg}] <= mem_data_in;
            if (last_word)
                tag_mem[req_index] <= req_tag;
        end
    end

    assign pc_ready_out       = (state_reg == IDLE);
    assign icache_have_input  = have_reg;
    assign icache_instr_input = instr_reg;
    assign mem_req_out        = mem_req_reg;
    assign mem_addr_out       = mem_addr_reg;
endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: directed scenarios followed by randomized fetches checked
// against a tag/valid reference cache and a fixed memory image.
module tb_icache_fetch;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        pc_valid_in = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic        pc_ready_out;
    logic        if_full_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        icache_have_input;
    logic [31:0] icache_instr_input;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_valid_in = 1'b0;
    logic [31:0] mem_data_in = 32'd0;

    icache_fetch #(.INDEX_BITS(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .pc_valid_in(pc_valid_in), .pc_in(pc_in), .pc_ready_out(pc_ready_out),
        .if_full_in(if_full_in), .flush_in(flush_in),
        .icache_have_input(icache_have_input), .icache_instr_input(icache_instr_input),
        .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
        .mem_valid_in(mem_valid_in), .mem_data_in(mem_data_in)
    );

    always #5 clk_in = ~clk_in;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          prev_have = 1'b0;
    bit          mem_stall = 1'b0;
    logic [31:0] addr_q[$];
    int          pulse_cyc[$];
    logic [31:0] pulse_data[$];

    // reference cache: which tag each line holds, if any
    bit          mvalid [64];
    logic [21:0] mtag   [64];

    logic [31:0] cur_pc;
    bit          cur_hit;
    int          acc_cyc;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %-14s observed=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w[31:4] == 28'd0)
            return 32'h11 * ({30'd0, w[3:2]} + 32'd1);
        return (w * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    // One clock: note any refill word the DUT takes at this edge, then sample and answer memory.
    task automatic tick();
        if (mem_valid_in && mem_req_out && rdy_in && !flush_in && !rst_in)
            addr_q.push_back(mem_addr_out);
        @(posedge clk_in);
        #1;
        cyc++;
        if (icache_have_input) begin
            check_value("have_gap", {31'd0, prev_have}, 32'd0);
            pulse_cyc.push_back(cyc);
            pulse_data.push_back(icache_instr_input);
        end
        prev_have   = icache_have_input;
        mem_valid_in = mem_req_out && (!mem_stall || ($urandom_range(0, 3) != 0));
        mem_data_in  = mem_word(mem_addr_out);
    endtask

    task automatic start_req(input logic [31:0] pc, input bit full);
        int n;
        cur_pc  = pc;
        cur_hit = mvalid[pc[9:4]] && (mtag[pc[9:4]] == pc[31:10]);
        addr_q.delete();
        pulse_cyc.delete();
        pulse_data.delete();
        pc_valid_in = 1'b1;
        pc_in       = pc;
        if_full_in  = full;
        n = 0;
        while (!pc_ready_out && n < 50) begin
            tick();
            n++;
        end
        check_value("pc_ready", {31'd0, pc_ready_out}, 32'd1);
        acc_cyc = cyc;
        tick();
        pc_valid_in = 1'b0;
        pc_in       = $urandom;
    endtask

    task automatic finish_req(input bit do_lat, input int exp_cyc);
        int          n;
        logic [31:0] base;
        logic [31:0] got;
        n = 0;
        while (pulse_cyc.size() == 0 && n < 400) begin
            tick();
            n++;
        end
        tick();
        check_value("pulse_count", pulse_cyc.size(), 32'd1);
        got = (pulse_data.size() > 0) ? pulse_data[0] : ~mem_word(cur_pc);
        check_value("instr", got, mem_word(cur_pc));
        $display("req pc=%h %s instr=%h words=%0d", cur_pc, cur_hit ? "hit " : "miss", got, addr_q.size());
        if (do_lat)
            check_value("pulse_cycle", (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1, exp_cyc);
        base = {cur_pc[31:4], 4'b0000};
        check_value("refill_words", addr_q.size(), cur_hit ? 32'd0 : 32'd4);
        for (int i = 0; i < addr_q.size() && i < 4; i++)
            check_value("refill_addr", addr_q[i], base + 32'(4 * i));
        check_value("mem_req_idle", {31'd0, mem_req_out}, 32'd0);
        if (!cur_hit) begin
            mvalid[cur_pc[9:4]] = 1'b1;
            mtag[cur_pc[9:4]]   = cur_pc[31:10];
        end
    endtask

    task automatic run_req(input logic [31:0] pc, input int full_cycles);
        int rel;
        start_req(pc, full_cycles > 0);
        for (int i = 0; i < full_cycles; i++) begin
            check_value("ready_busy", {31'd0, pc_ready_out}, 32'd0);
            check_value("held_pulse", pulse_cyc.size(), 32'd0);
            tick();
        end
        rel = cyc;
        if_full_in = 1'b0;
        if (full_cycles == 0)
            finish_req(cur_hit || !mem_stall, acc_cyc + (cur_hit ? 2 : 7));
        else
            finish_req(cur_hit, rel + 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int          n;
        logic [31:0] a_hold;
        logic [21:0] tg;
        for (int i = 0; i < 64; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = 22'd0;
        end

        repeat (3) tick();
        check_value("rst_ready", {31'd0, pc_ready_out}, 32'd1);
        check_value("rst_have", {31'd0, icache_have_input}, 32'd0);
        check_value("rst_instr", icache_instr_input, 32'd0);
        check_value("rst_mem_req", {31'd0, mem_req_out}, 32'd0);
        check_value("rst_mem_addr", mem_addr_out, 32'd0);
        rst_in = 1'b0;
        tick();

        // first fill of line 0, then hits, then a hit stalled by a full IF queue
        run_req(32'h0000_0004, 0);
        run_req(32'h0000_0000, 0);
        run_req(32'h0000_0008, 0);
        run_req(32'h0000_000C, 5);

        // same index, different tag: each evicts the other
        run_req(32'h0000_0400, 0);
        run_req(32'h0000_0000, 0);

        // flush after two refill words of 0x100
        start_req(32'h0000_0100, 1'b0);
        n = 0;
        while (addr_q.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check_value("flush_mem_req", {31'd0, mem_req_out}, 32'd0);
        check_value("flush_have", {31'd0, icache_have_input}, 32'd0);
        repeat (4) tick();
        check_value("flush_pulses", pulse_cyc.size(), 32'd0);
        check_value("flush_words", addr_q.size(), 32'd2);
        run_req(32'h0000_0104, 0);

        // freeze for three cycles in the middle of a refill
        start_req(32'h0000_0200, 1'b0);
        n = 0;
        while (addr_q.size() < 1 && n < 50) begin
            tick();
            n++;
        end
        a_hold = mem_addr_out;
        check_value("frz_addr_pre", a_hold, 32'h0000_0204);
        rdy_in = 1'b0;
        repeat (3) begin
            tick();
            check_value("frz_addr", mem_addr_out, a_hold);
            check_value("frz_mem_req", {31'd0, mem_req_out}, 32'd1);
            check_value("frz_have", {31'd0, icache_have_input}, 32'd0);
        end
        check_value("frz_words", addr_q.size(), 32'd1);
        rdy_in = 1'b1;
        finish_req(1'b0, 0);
        run_req(32'h0000_0208, 0);

        // randomized fetches with a stalling memory
        mem_stall = 1'b1;
        repeat (150) begin
            n  = $urandom_range(0, 2);
            tg = (n == 2) ? 22'h3FFFFF : 22'(n);
            run_req({tg, 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00},
                    $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
